// File: rtl/axis_pipe_buf.sv
// P_DEPTH-entry AXI-Stream elastic buffer with registered handshake, occupancy/packet
// status, and optional store-and-forward packet mode.
module axis_pipe_buf #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_USER_WIDTH = 1,
  parameter int P_DEPTH      = 4,
  parameter int P_PKT_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [P_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic [P_USER_WIDTH-1:0]     s_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [P_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [P_USER_WIDTH-1:0]     m_axis_tuser,
  output logic [$clog2(P_DEPTH):0]    occupancy,
  output logic [$clog2(P_DEPTH):0]    pkt_count,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = P_USER_WIDTH + 1 + P_DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(P_DEPTH);
  localparam bit PKT = (P_PKT_MODE != 0);

  logic [EW-1:0]  mem_q [P_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  occ_q, occ_d, pkt_q, pkt_d;
  logic           ready_q, ready_d, rel_q, rel_d;
  logic           push, pop, out_last, push_last, pop_last;
  logic [EW-1:0]  head;

  assign head          = mem_q[rd_ptr_q];
  assign out_last      = head[P_DATA_WIDTH];
  assign m_axis_tdata  = head[P_DATA_WIDTH-1:0];
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = head[EW-1:P_DATA_WIDTH+1];
  assign s_axis_tready = ready_q;
  assign occupancy     = occ_q;
  assign pkt_count     = pkt_q;
  assign full          = (occ_q == DEPTH_C);
  assign empty         = (occ_q == '0);
  // In packet mode a word is only offered once a whole packet is stored, or the
  // buffer filled with no packet end and must stream to avoid deadlock.
  assign m_axis_tvalid = !empty && (!PKT || (pkt_q != '0) || rel_q);

  always_comb begin
    push      = s_axis_tvalid & ready_q;
    pop       = m_axis_tvalid & m_axis_tready;
    push_last = push & s_axis_tlast;
    pop_last  = pop & out_last;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d     = occ_q;
    if (push && !pop)      occ_d = occ_q + CW'(1);
    else if (pop && !push) occ_d = occ_q - CW'(1);
    pkt_d     = pkt_q;
    if (push_last && !pop_last)      pkt_d = pkt_q + CW'(1);
    else if (pop_last && !push_last) pkt_d = pkt_q - CW'(1);
    ready_d   = (occ_d != DEPTH_C);
    rel_d     = PKT && ((rel_q && !pop_last) || (occ_d == DEPTH_C && pkt_d == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      ready_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      ready_q  <= ready_d;
      rel_q    <= rel_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end
endmodule
